// File: rtl/l1d_port_arbiter.sv
// l1d_port_arbiter: round-robin arbiter sharing one L1D cache port among
// NUM_REQ requesters, with a single outstanding request and a flush path.
// Optional feature: define L1D_ARB_STATS_EN to add per-requester saturating
// grant counters on output grant_count.
//
// Handshake: a requester transfer happens in the cycle where req_valid[i] and
// req_ready[i] are both high; req_ready is a combinational one-hot grant that
// is only raised in IDLE when the cache is ready and no flush is pending, and
// the cache request (c_req_*) is presented in that same cycle.
module l1d_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*4-1:0]          req_byte_en,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_rdata,
  output logic                          resp_hit,
  input  logic                          flush_req,
  output logic                          flush_done,
  output logic                          c_req_valid,
  output logic                          c_req_we,
  output logic [ADDR_WIDTH-1:0]         c_req_addr,
  output logic [DATA_WIDTH-1:0]         c_req_wdata,
  output logic [3:0]                    c_req_byte_en,
  input  logic                          c_ready,
  input  logic                          c_resp_valid,
  input  logic [DATA_WIDTH-1:0]         c_resp_rdata,
  input  logic                          c_resp_hit,
  output logic                          c_flush_req,
  output logic [1:0]                    dbg_state
`ifdef L1D_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         grant_count
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_RESP   = 2'd1,
    FLUSH_ISSUE = 2'd2,
    FLUSH_WAIT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W:0]     rr_sum;
  logic               any_valid;
  logic               grant;

  assign dbg_state = state_q;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    rr_sum    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (rr_sum >= (PTR_W+1)'(NUM_REQ)) rr_sum = rr_sum - (PTR_W+1)'(NUM_REQ);
      if (!any_valid && req_valid[rr_sum[PTR_W-1:0]]) begin
        any_valid = 1'b1;
        winner    = rr_sum[PTR_W-1:0];
      end
    end
  end

  // A grant needs an idle port, a ready cache and no pending flush; gated by
  // rst_n so the combinational grant stays quiet while reset is asserted.
  assign grant = rst_n && (state_q == IDLE) && c_ready && !flush_req && any_valid;

  // Mux the winner's request fields onto the cache port.
  always_comb begin
    c_req_we      = 1'b0;
    c_req_addr    = '0;
    c_req_wdata   = '0;
    c_req_byte_en = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == PTR_W'(i)) begin
        c_req_we      = req_we[i];
        c_req_addr    = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        c_req_wdata   = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        c_req_byte_en = req_byte_en[i*4 +: 4];
      end
    end
  end

  // Next-state and output decode for the arbiter FSM.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    req_ready   = '0;
    c_req_valid = 1'b0;
    resp_valid  = '0;
    resp_rdata  = '0;
    resp_hit    = 1'b0;
    c_flush_req = 1'b0;
    flush_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          if (c_ready) state_d = FLUSH_ISSUE;
        end else if (grant) begin
          req_ready[winner] = 1'b1;
          c_req_valid       = 1'b1;
          owner_d           = winner;
          rr_ptr_d          = (winner == PTR_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
          state_d           = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (c_resp_valid) begin
          resp_valid[owner_q] = 1'b1;
          resp_rdata          = c_resp_rdata;
          resp_hit            = c_resp_hit;
          state_d             = IDLE;
        end
      end
      FLUSH_ISSUE: begin
        c_flush_req = 1'b1;
        state_d     = FLUSH_WAIT;
      end
      FLUSH_WAIT: begin
        if (c_ready) begin
          flush_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, round-robin pointer and owner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

`ifdef L1D_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    // Saturating count of grants won by requester g.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[g] <= '0;
      end else if (grant && (winner == PTR_W'(g)) && (cnt_q[g] != 16'hFFFF)) begin
        cnt_q[g] <= cnt_q[g] + 16'd1;
      end
    end
    assign grant_count[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_l1d_port_arbiter.sv
// Testbench for l1d_port_arbiter: directed vector table, hand-written
// multi-cycle sequences (long response, flush ordering, mid-transaction
// reset, optional grant counters) and a randomized phase, all checked against
// a transaction-level reference model.
module tb_l1d_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [N-1:0]    req_valid, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*4-1:0]  req_byte_en;
  logic [N-1:0]    req_ready, resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic            resp_hit;
  logic            flush_req, flush_done;
  logic            c_req_valid, c_req_we;
  logic [AW-1:0]   c_req_addr;
  logic [DW-1:0]   c_req_wdata;
  logic [3:0]      c_req_byte_en;
  logic            c_ready, c_resp_valid, c_resp_hit;
  logic [DW-1:0]   c_resp_rdata;
  logic            c_flush_req;
  logic [1:0]      dbg_state;
`ifdef L1D_ARB_STATS_EN
  logic [N*16-1:0] grant_count;
`endif

  l1d_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_byte_en(req_byte_en),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .flush_req(flush_req), .flush_done(flush_done),
    .c_req_valid(c_req_valid), .c_req_we(c_req_we), .c_req_addr(c_req_addr),
    .c_req_wdata(c_req_wdata), .c_req_byte_en(c_req_byte_en),
    .c_ready(c_ready), .c_resp_valid(c_resp_valid),
    .c_resp_rdata(c_resp_rdata), .c_resp_hit(c_resp_hit),
    .c_flush_req(c_flush_req), .dbg_state(dbg_state)
`ifdef L1D_ARB_STATS_EN
    , .grant_count(grant_count)
`endif
  );

  // Per-requester request payloads, packed onto the DUT bus every cycle.
  logic [AW-1:0] a_addr  [N];
  logic [DW-1:0] a_wdata [N];
  logic [3:0]    a_be    [N];

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0]  valid;
    logic          flush;
    logic          crdy;
    logic          crv;
    logic [DW-1:0] rdata;
    logic [N-1:0]  e_ready;
    logic [N-1:0]  e_resp;
    logic [DW-1:0] e_rdata;
    logic          e_cfl;
    logic          e_done;
  } vec_t;

  vec_t tbl [17];
  vec_t v_none;

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  // Transaction view: which requester (if any) owns the port, where the
  // round-robin search starts next, and the flush phase (0 none, 1 issuing
  // to the cache, 2 waiting for the cache to become ready again).
  int m_ptr, m_owner, m_flush;
  int m_cnt [N];

  task automatic model_reset();
    m_ptr   = 0;
    m_owner = -1;
    m_flush = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: apply inputs at the negedge, check 1ns later against the
  // model (and the table record when use_v), advance the model, then wait
  // for the next negedge.
  task automatic cycle(input bit use_v, input vec_t v);
    logic [N-1:0]    e_ready, e_resp;
    logic [DW-1:0]   e_rdata;
    logic            e_hit, e_cfl, e_done, e_cvalid;
    logic [N*16-1:0] e_gc;
    int w, nx_ptr, nx_owner, nx_flush;
    if (use_v) begin
      req_valid    = v.valid;
      flush_req    = v.flush;
      c_ready      = v.crdy;
      c_resp_valid = v.crv;
      c_resp_rdata = v.rdata;
      c_resp_hit   = v.rdata[0];
    end
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]   = a_addr[i];
      req_wdata[i*DW +: DW]  = a_wdata[i];
      req_byte_en[i*4 +: 4]  = a_be[i];
    end
    #1;
    e_ready = '0; e_resp = '0; e_rdata = '0;
    e_hit = 1'b0; e_cfl = 1'b0; e_done = 1'b0; e_cvalid = 1'b0;
    w = -1; nx_ptr = m_ptr; nx_owner = m_owner; nx_flush = m_flush;
    if (m_flush == 1) begin
      e_cfl    = 1'b1;
      nx_flush = 2;
    end else if (m_flush == 2) begin
      if (c_ready) begin
        e_done   = 1'b1;
        nx_flush = 0;
      end
    end else if (m_owner >= 0) begin
      if (c_resp_valid) begin
        e_resp[m_owner] = 1'b1;
        e_rdata         = c_resp_rdata;
        e_hit           = c_resp_hit;
        nx_owner        = -1;
      end
    end else if (flush_req) begin
      if (c_ready) nx_flush = 1;
    end else if (c_ready) begin
      for (int k = 0; k < N; k++)
        if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) begin
        e_ready[w] = 1'b1;
        e_cvalid   = 1'b1;
        nx_owner   = w;
        nx_ptr     = (w + 1) % N;
        if (m_cnt[w] < 65535) m_cnt[w] = m_cnt[w] + 1;
      end
    end
    chk("req_ready",   64'(req_ready),   64'(e_ready));
    chk("resp_valid",  64'(resp_valid),  64'(e_resp));
    chk("resp_rdata",  64'(resp_rdata),  64'(e_rdata));
    chk("resp_hit",    64'(resp_hit),    64'(e_hit));
    chk("c_req_valid", 64'(c_req_valid), 64'(e_cvalid));
    chk("c_flush_req", 64'(c_flush_req), 64'(e_cfl));
    chk("flush_done",  64'(flush_done),  64'(e_done));
    if (w >= 0) begin
      chk("c_req_addr",    64'(c_req_addr),    64'(a_addr[w]));
      chk("c_req_we",      64'(c_req_we),      64'(req_we[w]));
      chk("c_req_wdata",   64'(c_req_wdata),   64'(a_wdata[w]));
      chk("c_req_byte_en", 64'(c_req_byte_en), 64'(a_be[w]));
    end
    if (use_v) begin
      chk("tbl_req_ready",   64'(req_ready),   64'(v.e_ready));
      chk("tbl_resp_valid",  64'(resp_valid),  64'(v.e_resp));
      chk("tbl_resp_rdata",  64'(resp_rdata),  64'(v.e_rdata));
      chk("tbl_c_flush_req", 64'(c_flush_req), 64'(v.e_cfl));
      chk("tbl_flush_done",  64'(flush_done),  64'(v.e_done));
    end
    m_ptr = nx_ptr; m_owner = nx_owner; m_flush = nx_flush;
    @(negedge clk);
    for (int i = 0; i < N; i++) e_gc[i*16 +: 16] = 16'(m_cnt[i]);
`ifdef L1D_ARB_STATS_EN
    chk("grant_count", 64'(grant_count), 64'(e_gc));
`endif
  endtask

  task automatic step();
    cycle(1'b0, v_none);
  endtask

  task automatic tv(input logic [N-1:0] valid, input logic flush, input logic crdy,
                    input logic crv, input logic [DW-1:0] rdata,
                    input logic [N-1:0] e_ready, input logic [N-1:0] e_resp,
                    input logic [DW-1:0] e_rdata, input logic e_cfl, input logic e_done);
    vec_t v;
    v = '{valid, flush, crdy, crv, rdata, e_ready, e_resp, e_rdata, e_cfl, e_done};
    cycle(1'b1, v);
  endtask

  // Outputs that must be zero while rst_n is low.
  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"},   64'(req_ready),   64'd0);
    chk({tag, "_resp_valid"},  64'(resp_valid),  64'd0);
    chk({tag, "_resp_rdata"},  64'(resp_rdata),  64'd0);
    chk({tag, "_c_req_valid"}, 64'(c_req_valid), 64'd0);
    chk({tag, "_c_flush_req"}, 64'(c_flush_req), 64'd0);
    chk({tag, "_flush_done"},  64'(flush_done),  64'd0);
  endtask

  // Full reset with busy-looking inputs to prove the outputs stay quiet.
  task automatic do_reset();
    rst_n        = 1'b0;
    req_valid    = '1;
    flush_req    = 1'b0;
    c_ready      = 1'b1;
    c_resp_valid = 1'b1;
    c_resp_rdata = 32'hFFFF_FFFF;
    c_resp_hit   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_all_zero("reset");
    model_reset();
    @(negedge clk);
    req_valid    = '0;
    c_resp_valid = 1'b0;
    rst_n        = 1'b1;
  endtask

  // ---------------- main test ----------------
  initial begin
    v_none       = '{'0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0};
    req_we       = 4'b1010;
    req_addr     = '0;
    req_wdata    = '0;
    req_byte_en  = '0;
    for (int i = 0; i < N; i++) begin
      a_addr[i]  = 32'h1000 * (i + 1);
      a_wdata[i] = 32'h5A00_0000 + i;
      a_be[i]    = 4'(i + 1);
    end

    // All four requesting, cache responding immediately: 0,1,2,3,0.
    // c_resp_valid is also high in the grant cycles and must be ignored there.
    for (int k = 0; k < 10; k++) begin
      logic [N-1:0] oh;
      oh = N'(1) << ((k / 2) % N);
      if (k % 2 == 0)
        tbl[k] = '{4'b1111, 1'b0, 1'b1, 1'b1, 32'hA000 + k, oh, 4'b0000, 32'h0, 1'b0, 1'b0};
      else
        tbl[k] = '{4'b1111, 1'b0, 1'b1, 1'b1, 32'hA000 + k, 4'b0000, oh, 32'hA000 + k, 1'b0, 1'b0};
    end
    // Flush and requester 1 together in IDLE: flush first, grant after done.
    tbl[10] = '{4'b0010, 1'b1, 1'b0, 1'b0, 32'h0,  4'b0000, 4'b0000, 32'h0,  1'b0, 1'b0};
    tbl[11] = '{4'b0010, 1'b1, 1'b1, 1'b0, 32'h0,  4'b0000, 4'b0000, 32'h0,  1'b0, 1'b0};
    tbl[12] = '{4'b0010, 1'b0, 1'b1, 1'b1, 32'h9,  4'b0000, 4'b0000, 32'h0,  1'b1, 1'b0};
    tbl[13] = '{4'b0010, 1'b0, 1'b0, 1'b0, 32'h0,  4'b0000, 4'b0000, 32'h0,  1'b0, 1'b0};
    tbl[14] = '{4'b0010, 1'b0, 1'b1, 1'b0, 32'h0,  4'b0000, 4'b0000, 32'h0,  1'b0, 1'b1};
    tbl[15] = '{4'b0010, 1'b0, 1'b1, 1'b0, 32'h0,  4'b0010, 4'b0000, 32'h0,  1'b0, 1'b0};
    tbl[16] = '{4'b0000, 1'b0, 1'b1, 1'b1, 32'h55, 4'b0000, 4'b0010, 32'h55, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 17; i++) cycle(1'b1, tbl[i]);

    // Long-latency load from requester 2; others pile up meanwhile.
    a_addr[2] = 32'h100;
    req_we    = 4'b0000;
    tv(4'b0100, 1'b0, 1'b1, 1'b0, 32'h0, 4'b0100, 4'b0000, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      tv(4'b1111, 1'b0, 1'b1, 1'b0, 32'h0, 4'b0000, 4'b0000, 32'h0, 1'b0, 1'b0);
    tv(4'b1111, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 4'b0000, 4'b0100, 32'hDEADBEEF, 1'b0, 1'b0);

    // Flush raised while a request is outstanding: response first, then flush.
    tv(4'b1000, 1'b0, 1'b1, 1'b0, 32'h0,  4'b1000, 4'b0000, 32'h0,  1'b0, 1'b0);
    tv(4'b0000, 1'b1, 1'b1, 1'b0, 32'h0,  4'b0000, 4'b0000, 32'h0,  1'b0, 1'b0);
    tv(4'b0000, 1'b1, 1'b1, 1'b1, 32'h77, 4'b0000, 4'b1000, 32'h77, 1'b0, 1'b0);
    tv(4'b0000, 1'b1, 1'b1, 1'b0, 32'h0,  4'b0000, 4'b0000, 32'h0,  1'b0, 1'b0);
    tv(4'b0000, 1'b0, 1'b1, 1'b0, 32'h0,  4'b0000, 4'b0000, 32'h0,  1'b1, 1'b0);
    tv(4'b0000, 1'b0, 1'b1, 1'b0, 32'h0,  4'b0000, 4'b0000, 32'h0,  1'b0, 1'b1);

    // Reset while requester 1 is waiting for its response.
    tv(4'b0010, 1'b0, 1'b1, 1'b0, 32'h0, 4'b0010, 4'b0000, 32'h0, 1'b0, 1'b0);
    req_valid    = 4'b1111;
    c_ready      = 1'b1;
    c_resp_valid = 1'b1;
    c_resp_rdata = 32'hBAD0_BAD0;
    rst_n        = 1'b0;
    #1;
    chk_all_zero("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    // No stale response, and the pointer restarts at requester 0.
    tv(4'b1111, 1'b0, 1'b1, 1'b1, 32'h1234, 4'b0001, 4'b0000, 32'h0, 1'b0, 1'b0);
    tv(4'b0000, 1'b0, 1'b1, 1'b1, 32'h4321, 4'b0000, 4'b0001, 32'h4321, 1'b0, 1'b0);

`ifdef L1D_ARB_STATS_EN
    // Three grants to requester 3 from a clean reset.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tv(4'b1000, 1'b0, 1'b1, 1'b0, 32'h0, 4'b1000, 4'b0000, 32'h0, 1'b0, 1'b0);
      tv(4'b0000, 1'b0, 1'b1, 1'b1, 32'h3, 4'b0000, 4'b1000, 32'h3, 1'b0, 1'b0);
    end
    chk("grant_count_req3x3", 64'(grant_count), 64'h0003_0000_0000_0000);
`endif

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      req_valid    = N'($urandom_range(0, (1 << N) - 1));
      req_we       = N'($urandom_range(0, (1 << N) - 1));
      flush_req    = ($urandom_range(0, 9) == 0);
      c_ready      = ($urandom_range(0, 3) != 0);
      c_resp_valid = ($urandom_range(0, 2) == 0);
      c_resp_rdata = $urandom;
      c_resp_hit   = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        a_addr[i]  = $urandom;
        a_wdata[i] = $urandom;
        a_be[i]    = 4'($urandom_range(0, 15));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
